// File: rtl/ysyx_23060042_pkg.sv
// Shared IFU definitions: widths, reset defaults, FSM states and queue payload.
package ysyx_23060042_pkg;

  localparam int unsigned XLEN         = 32;
  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
  localparam int unsigned IFU_FQ_DEPTH = 2;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/ysyx_23060042_FIFO.sv
// Registered circular queue with synchronous flush; head is always visible on o_data.
module ysyx_23060042_FIFO #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_data,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;
  logic             w_full;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_pop   = i_pop && (r_count != '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  // Credit accounting upstream must make this unreachable.
  always_ff @(posedge clk) begin
    if (rst_n && !i_flush) assert (!(i_push && w_full && !w_pop));
  end

endmodule

// File: rtl/ysyx_23060042_ifu.sv
// Instruction fetch unit: credit-limited fetch issue, in-order response retire,
// redirect flush with stale-response dropping, and a RUN/HALT FSM.
module ysyx_23060042_ifu
  import ysyx_23060042_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = IFU_RESET_PC,
  parameter int unsigned     FQ_DEPTH = IFU_FQ_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            halted
);

  localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
  localparam int unsigned SW = CW + 1;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [XLEN-1:0] w_fetch_pc_nxt;
  logic [XLEN-1:0] w_rsp_pc_nxt;
  logic [XLEN-1:0] w_redirect_tgt;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;
  logic [CW-1:0]   w_outstanding_nxt;
  logic [CW-1:0]   w_drop_cnt_nxt;
  logic [CW-1:0]   w_fq_count;
  logic            w_fq_empty;
  logic            w_credit;
  logic            w_req_fire;
  logic            w_drop;
  logic            w_push;
  logic            w_pop;
  fq_entry_t       w_push_entry;
  fq_entry_t       w_head;

  // Requests in flight plus buffered entries never exceed the queue depth.
  assign w_credit       = (SW'(r_outstanding) + SW'(w_fq_count)) < SW'(FQ_DEPTH);
  assign mem_req_valid  = rst_n && (r_state == RUN) && !halt && w_credit;
  assign mem_req_addr   = r_fetch_pc;
  assign w_req_fire     = mem_req_valid && mem_req_ready;
  assign w_drop         = mem_rsp_valid && (r_drop_cnt != '0);
  assign w_push         = mem_rsp_valid && !w_drop && !redirect_valid;
  assign w_pop          = inst_valid && inst_ready;
  assign w_redirect_tgt = redirect_pc & ~XLEN'(3);
  assign w_push_entry   = '{pc: r_rsp_pc, inst: mem_rsp_data};

  assign inst_valid = !w_fq_empty;
  assign inst       = w_head.inst;
  assign inst_pc    = w_head.pc;
  assign halted     = (r_state == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= RUN;
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_rsp_pc      <= w_rsp_pc_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_drop_cnt    <= w_drop_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_fetch_pc_nxt    = r_fetch_pc;
    w_rsp_pc_nxt      = r_rsp_pc;
    w_outstanding_nxt = r_outstanding + CW'(w_req_fire) - CW'(mem_rsp_valid);
    w_drop_cnt_nxt    = r_drop_cnt - CW'(w_drop);

    case (r_state)
      RUN:  if (halt) w_state_nxt = HALT;
      HALT: w_state_nxt = HALT;
    endcase

    if (w_req_fire) w_fetch_pc_nxt = r_fetch_pc + XLEN'(4);
    if (w_push)     w_rsp_pc_nxt   = r_rsp_pc + XLEN'(4);

    // Everything still in flight after this cycle belongs to the old path.
    if (redirect_valid) begin
      w_fetch_pc_nxt = w_redirect_tgt;
      w_rsp_pc_nxt   = w_redirect_tgt;
      w_drop_cnt_nxt = w_outstanding_nxt;
    end
  end

  ysyx_23060042_FIFO #(
    .WIDTH ($bits(fq_entry_t)),
    .DEPTH (FQ_DEPTH)
  ) u_fq (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_fq_empty),
    .o_count (w_fq_count)
  );

endmodule

// File: doc/ysyx_23060042_ifu.md
YSYX_23060042_IFU -- requirements
Module: ysyx_23060042_IFU

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, first fetch address after reset.
REQ-002 Parameter FQ_DEPTH, default 2, instruction queue depth and maximum in-flight-plus-buffered fetches.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 mem_req_valid  output  1  fetch request valid.
REQ-006 mem_req_ready  input  1  memory accepts request.
REQ-007 mem_req_addr  output  32  fetch address, word aligned.
REQ-008 mem_rsp_valid  input  1  fetch data returned; responses arrive in request order; always accepted.
REQ-009 mem_rsp_data  input  32  fetched instruction word.
REQ-010 inst_valid  output  1  instruction to the decoder valid.
REQ-011 inst_ready  input  1  decoder accepts instruction.
REQ-012 inst  output  32  instruction word to the decoder.
REQ-013 inst_pc  output  32  address of inst.
REQ-014 redirect_valid  input  1  jump or taken branch; flush and refetch.
REQ-015 redirect_pc  input  32  new fetch target.
REQ-016 halt  input  1  ebreak decoded; stop fetching.
REQ-017 halted  output  1  high in HALT state.

Function
REQ-018 Handshakes complete when valid and ready are both high on a rising edge; a raised valid and its payload remain stable until the handshake completes or a redirect occurs.
REQ-019 mem_req_valid is asserted in RUN when outstanding plus queue count is less than FQ_DEPTH; mem_req_addr equals fetch_pc.
REQ-020 Each request handshake increments fetch_pc by 4 (wrap modulo 2^32) and increments outstanding.
REQ-021 Each response decrements outstanding; if drop_cnt is nonzero, the response is discarded and drop_cnt decrements; otherwise {rsp_pc, mem_rsp_data} is pushed into the queue and rsp_pc increments by 4.
REQ-022 Queue entries are registered: inst_valid rises one cycle after the accepting response edge; inst and inst_pc come from the queue head; a handshake pops the head.
REQ-023 Credit accounting guarantees the queue never overflows; pushing to a full queue is a design error, asserted in simulation.
REQ-024 On redirect_valid: the queue is flushed; fetch_pc and rsp_pc are set to {redirect_pc[31:2], 2'b00}; drop_cnt is set to the outstanding count after this cycle's request and response updates.
REQ-025 A redirect in the same cycle as a request handshake counts that request as dropped.
REQ-026 A redirect in the same cycle as a response discards that response.
REQ-027 A redirect in the same cycle as an inst handshake keeps the consumption; the instruction was delivered.
REQ-028 Simultaneous push and pop on a full queue is legal; the count is unchanged.
REQ-029 FSM state RUN (reset state): issuing allowed.
REQ-030 FSM transition RUN to HALT when halt is high; mem_req_valid drops the same cycle.
REQ-031 In HALT, in-flight responses still retire and the queue drains to the decoder; HALT is left only by reset.
REQ-032 A redirect in HALT updates the pointers and flush but issues no request.

Reset
REQ-033 While rst_n is low: mem_req_valid=0, inst_valid=0, halted=0, fetch_pc=rsp_pc=RESET_PC, outstanding=drop_cnt=0, queue empty, state RUN.
REQ-034 The first request, at RESET_PC, appears in the first cycle after rst_n deasserts.
REQ-035 Reset mid-operation abandons in-flight responses; the memory model is reset together with this block.

Structure
REQ-036 RESET_PC default, XLEN=32 and FQ_DEPTH belong in shared package ysyx_23060042_pkg, together with a state enum {RUN, HALT}.
REQ-037 The queue is a sub-module, ysyx_23060042_FIFO (parameterised width and depth, flush input); the counters and FSM stay in the IFU.

Verification
REQ-038 Zero-latency memory, inst_ready=1 -> inst_pc sequence 8000_0000, 8000_0004, 8000_0008, one instruction per cycle after fill.
REQ-039 inst_ready=0 for 10 cycles -> exactly 2 requests issued, queue full, mem_req_valid=0, no data lost on release.
REQ-040 Two outstanding requests, then redirect to 8000_0100 -> both old responses dropped, next inst_pc=8000_0100.
REQ-041 Redirect coincident with a response and a request handshake -> neither appears at the decoder; next inst_pc is the redirect target.
REQ-042 halt while 1 request is in flight -> no new mem_req_valid, the in-flight instruction is still delivered, halted=1.
REQ-043 rst_n pulsed low mid-stream -> outputs return to reset values asynchronously; first request after release is 8000_0000.
